// File: rtl/xor_share_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : xor_share_ctrl_pkg
// Description : Shared types and defaults for the xor_share_ctrl scheduler:
//               FSM state encoding, default N/W/IDW, result parity helper.
// Revision    : 1.0 - initial release
// ============================================================================
package xor_share_ctrl_pkg;

    // Default geometry: four requesters sharing an 8-bit fold.
    localparam int DEF_N   = 4;
    localparam int DEF_W   = 8;
    localparam int DEF_IDW = 2;

    // Scheduler states, 2-bit encoding.
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_DONE = 2'd2
    } state_e;

    // Reduction XOR of a word, zero-extended to 64 bits by the caller.
    function automatic logic fold_parity(input logic [63:0] v);
        return ^v;
    endfunction

endpackage : xor_share_ctrl_pkg
`default_nettype wire

// File: rtl/xor_share_ctrl_rr_pick.sv
`default_nettype none
// ============================================================================
// Module      : xor_share_ctrl_rr_pick
// Description : Purely combinational round-robin picker. Starting just after
//               the last-grant pointer and wrapping modulo N, selects the
//               first asserted request. Returns the winner one-hot, its index
//               and an any-request flag.
// Revision    : 1.0 - initial release
// ============================================================================
module xor_share_ctrl_rr_pick #(
    parameter int N   = 4,
    parameter int IDW = 2
) (
    input  logic [N-1:0]   req_i,
    input  logic [IDW-1:0] ptr_i,
    output logic [N-1:0]   win_oh_o,
    output logic [IDW-1:0] win_idx_o,
    output logic           any_o
);

    // Candidate index walked around the ring, one step per loop iteration.
    logic [IDW-1:0] cand;

    // Scan ptr+1, ptr+2, ... ptr+N (mod N); the first hit wins.
    always_comb begin
        win_oh_o  = '0;
        win_idx_o = '0;
        any_o     = 1'b0;
        cand      = ptr_i;
        for (int k = 0; k < N; k++) begin
            cand = (cand == IDW'(N - 1)) ? '0 : cand + 1'b1;
            if (!any_o && req_i[cand]) begin
                any_o           = 1'b1;
                win_oh_o[cand]  = 1'b1;
                win_idx_o       = cand;
            end
        end
    end

endmodule : xor_share_ctrl_rr_pick
`default_nettype wire

// File: rtl/xor_share_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : xor_share_ctrl
// Description : Shares one W-bit XOR fold among N requesters. Grants one
//               requester at a time in round-robin order, folds its beats
//               until the last one, then emits a one-cycle result pulse with
//               the folded word and the requester index.
//               Optional macro XOR_PARITY_EN adds the res_parity output.
//               IDW must equal clog2(N).
// Revision    : 1.0 - initial release
// ============================================================================
module xor_share_ctrl
    import xor_share_ctrl_pkg::*;
#(
    parameter int N   = DEF_N,
    parameter int W   = DEF_W,
    parameter int IDW = DEF_IDW
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N-1:0]     req,
    output logic [N-1:0]     gnt,
    input  logic [N*W-1:0]   in_data,
    input  logic [N-1:0]     in_valid,
    input  logic [N-1:0]     in_last,
    output logic [N-1:0]     in_ready,
    output logic             res_valid,
    output logic [W-1:0]     res_data,
    output logic [IDW-1:0]   res_id
`ifdef XOR_PARITY_EN
    ,
    output logic             res_parity
`endif
);

    // ------------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------------
    state_e         state_q;
    logic [N-1:0]   gnt_q;
    logic [IDW-1:0] ptr_q;       // last-grant pointer, also the current owner
    logic [W-1:0]   acc_q;
    logic           res_valid_q;
    logic [W-1:0]   res_data_q;
    logic [IDW-1:0] res_id_q;

    // ------------------------------------------------------------------------
    // Arbitration
    // ------------------------------------------------------------------------
    logic [N-1:0]   pick_oh;
    logic [IDW-1:0] pick_idx;
    logic           pick_any;

    xor_share_ctrl_rr_pick #(
        .N   (N),
        .IDW (IDW)
    ) u_rr_pick (
        .req_i     (req),
        .ptr_i     (ptr_q),
        .win_oh_o  (pick_oh),
        .win_idx_o (pick_idx),
        .any_o     (pick_any)
    );

    // ------------------------------------------------------------------------
    // Owner lane selection: only the granted requester's lane is observed,
    // so traffic on other lanes cannot disturb the fold.
    // ------------------------------------------------------------------------
    logic [W-1:0] word_g;
    logic         valid_g;
    logic         last_g;
    logic         beat;
    logic [W-1:0] acc_d;

    // Mux the owner's data, valid and last out of the flattened inputs.
    always_comb begin
        word_g  = '0;
        valid_g = 1'b0;
        last_g  = 1'b0;
        for (int i = 0; i < N; i++) begin
            if (ptr_q == IDW'(i)) begin
                word_g  = in_data[i*W +: W];
                valid_g = in_valid[i];
                last_g  = in_last[i];
            end
        end
    end

    // Ready mirrors the grant only while a burst is in flight.
    assign in_ready = (state_q == S_BUSY) ? gnt_q : '0;
    assign beat     = valid_g & (|in_ready);
    assign acc_d    = acc_q ^ word_g;

    // ------------------------------------------------------------------------
    // Scheduler FSM with registered outputs.
    // ------------------------------------------------------------------------
`ifdef XOR_PARITY_EN
    logic res_parity_q;
`endif

    // IDLE arbitrates, BUSY folds the owner's beats, DONE presents the result.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            gnt_q       <= '0;
            ptr_q       <= IDW'(N - 1);
            acc_q       <= '0;
            res_valid_q <= 1'b0;
            res_data_q  <= '0;
            res_id_q    <= '0;
`ifdef XOR_PARITY_EN
            res_parity_q <= 1'b0;
`endif
        end else begin
            case (state_q)
                S_IDLE: begin
                    res_valid_q <= 1'b0;
                    if (pick_any) begin
                        gnt_q   <= pick_oh;
                        ptr_q   <= pick_idx;
                        acc_q   <= '0;
                        state_q <= S_BUSY;
                    end
                end

                S_BUSY: begin
                    // Stalls (no valid on the owner lane) leave acc untouched;
                    // a dropped req is deliberately not examined here.
                    if (beat) begin
                        acc_q <= acc_d;
                        if (last_g) begin
                            res_data_q  <= acc_d;
                            res_id_q    <= ptr_q;
                            res_valid_q <= 1'b1;
`ifdef XOR_PARITY_EN
                            res_parity_q <= fold_parity(64'(acc_d));
`endif
                            gnt_q   <= '0;
                            state_q <= S_DONE;
                        end
                    end
                end

                S_DONE: begin
                    // Result pulse lasts exactly this state; data/id hold.
                    res_valid_q <= 1'b0;
                    state_q     <= S_IDLE;
                end

                default: begin
                    gnt_q       <= '0;
                    res_valid_q <= 1'b0;
                    state_q     <= S_IDLE;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------------
    assign gnt       = gnt_q;
    assign res_valid = res_valid_q;
    assign res_data  = res_data_q;
    assign res_id    = res_id_q;
`ifdef XOR_PARITY_EN
    assign res_parity = res_parity_q;
`endif

endmodule : xor_share_ctrl
`default_nettype wire

// File: doc/xor_share_ctrl.md
Name: xor_share_ctrl

Overview:
Scheduler that shares one W-bit XOR accumulation datapath among N requesters. It grants the datapath to one requester at a time in round-robin order and streams that requester's words through the XOR fold until its last beat. It then returns the folded result tagged with the requester index. It sits between several producer blocks and a single XOR/checksum resource, and is the sequencing layer above the basic xor gate cells.

Parameters:
N, 4, number of requesters (2..8)
W, 8, data word width in bits
IDW, 2, width of requester id; must equal clog2(N)

Ports:
clk  in  1  single clock, rising edge
rst  in  1  synchronous reset, active-high
req  in  N  req[i]=1: requester i wants the datapath
gnt  out  N  one-hot grant, registered; all zero when no owner
in_data  in  N*W  flattened words; requester i uses bits [i*W +: W]
in_valid  in  N  per-requester beat valid
in_last  in  N  per-requester last-beat marker, qualified by in_valid
in_ready  out  N  equals gnt while in BUSY; 0 otherwise
res_valid  out  1  one-cycle pulse, result available
res_data  out  W  XOR fold of all accepted beats of the burst
res_id  out  IDW  index of requester that produced res_data

Behaviour:
- Reset: one clock, synchronous, active-high. When rst=1 at a clock edge:
  - state=IDLE; gnt=0, in_ready=0, res_valid=0, res_data=0, res_id=0, acc=0.
  - last-grant pointer = N-1, so requester 0 has first priority.
- Reset mid-burst: the burst is abandoned, no result is produced, and the pointer returns to N-1.
- States: IDLE, BUSY, DONE, encoded in 2 bits.
- IDLE:
  - If req != 0, choose the first set bit searching upward from pointer+1, wrapping modulo N.
  - Next cycle: gnt one-hot on the winner, pointer = winner, acc = 0, state = BUSY.
  - If req == 0, stay in IDLE.
- Grant latency: req sampled at edge t gives gnt at edge t+1.
- BUSY:
  - in_ready[g] = 1 for the granted g only.
  - A beat is accepted when in_valid[g] & in_ready[g]; then acc <= acc ^ word_g.
  - in_valid, in_last and data from non-granted requesters are ignored.
  - If the accepted beat has in_last[g]=1:
    - res_data <= acc ^ word_g, res_id <= g, res_valid <= 1;
    - gnt <= 0, state <= DONE.
  - Cycles with in_valid[g]=0 are stalls; acc holds.
  - A drop in req[g] during BUSY is ignored: the grant is held until the last beat.
- DONE: res_valid=1 for exactly this one cycle, then IDLE.
  - res_data and res_id hold their values until the next result.
- Throughput: the earliest next grant is 2 cycles after the last beat (DONE, then IDLE arbitration).
- Single-beat burst (valid and last on the first BUSY cycle): res_data = that word.
- All requesters asserted continuously: grants rotate 0,1,2,3,0,...
- No starvation: a continuously requesting requester waits at most N-1 bursts.
- Width: acc and res_data are W bits; XOR has no carry, so no overflow.

Optional Feature:
XOR_PARITY_EN
- Defined:
  - Adds output port res_parity (1 bit) = reduction XOR of res_data.
  - It is registered alongside res_data and is 0 on reset.
- Undefined: the port and its logic are absent; all other behaviour is identical.

Decomposition:
- Shared include xor_share_defs.vh holds:
  - state encodings S_IDLE=2'd0, S_BUSY=2'd1, S_DONE=2'd2;
  - default N/W constants.
- One sub-module, rr_pick: purely combinational.
  - Inputs: req[N], ptr[IDW].
  - Outputs: winner one-hot [N], winner index [IDW], any.
  - Instantiated once.

Test Plan (N=4, W=8):
- Reset: assert rst mid-burst of requester 2 -> next cycle gnt=0, res_valid=0, state IDLE; then req=4'b1111 -> gnt=4'b0001.
- Single burst: req[1] with beats 8'hA5, 8'h3C, 8'hFF (last) -> res_valid pulse 1 cycle after the last beat, res_data=8'h66, res_id=1.
- Round robin: req=4'b1111 held, each burst 1 beat of 8'h01<<i -> res_id sequence 0,1,2,3,0 with res_data 01,02,04,08,01.
- Stalls and interference: granted requester 3 inserts 2 idle cycles between beats 8'h0F, 8'hF0(last), while requester 0 drives valid with 8'hFF -> res_data=8'hFF, res_id=3, in_ready[0] never 1.
- Single-beat burst plus req drop: req[2] sends 8'h5A with last on the first BUSY cycle -> res_data=8'h5A. In a separate burst, requester 2 drops req mid-burst -> gnt held until the last beat.
- With XOR_PARITY_EN: result 8'h66 -> res_parity=0; result 8'h07 -> res_parity=1.
